// File: rtl/imem_dp.sv
// imem_dp: instruction memory with registered fetch port, byte-enabled debug/loader port and init sequencer
module imem_dp #(
    parameter int DEPTH = 256,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_WORD = 32'h00000013
) (
    input  logic                    clk,
    input  logic                    sys_rst_n,
    input  logic                    fetch_req,
    input  logic [ADDR_WIDTH-1:0]   fetch_addr,
    output logic                    fetch_ready,
    output logic                    fetch_valid,
    output logic [DATA_WIDTH-1:0]   fetch_data,
    output logic                    fetch_err,
    input  logic                    dbg_req,
    input  logic                    dbg_we,
    input  logic [DATA_WIDTH/8-1:0] dbg_be,
    input  logic [ADDR_WIDTH-1:0]   dbg_addr,
    input  logic [DATA_WIDTH-1:0]   dbg_wdata,
    output logic                    dbg_ready,
    output logic                    dbg_ack,
    output logic [DATA_WIDTH-1:0]   dbg_rdata,
    output logic                    dbg_err,
    output logic                    init_busy
);
    localparam int IW = $clog2(DEPTH);
    localparam int BW = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-2:0] DEPTH_A = (ADDR_WIDTH-1)'(DEPTH);
    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [0:0]            state;
    logic [IW-1:0]         cnt;
    logic [ADDR_WIDTH-3:0] f_idx, d_idx;
    logic                  f_ok, d_ok, f_go, d_go;

    always_comb begin
        init_busy = state == S_INIT;
        dbg_ready = !init_busy;
        fetch_ready = !init_busy && !dbg_req;
        f_idx = fetch_addr[ADDR_WIDTH-1:2];
        d_idx = dbg_addr[ADDR_WIDTH-1:2];
        f_ok = ({1'b0, f_idx} < DEPTH_A) && (fetch_addr[1:0] == 2'b00);
        d_ok = ({1'b0, d_idx} < DEPTH_A) && (dbg_addr[1:0] == 2'b00);
        f_go = fetch_req && fetch_ready;
        d_go = dbg_req && dbg_ready;
    end

    // Array has no reset; the sequencer rewrites it after every reset instead.
    always_ff @(posedge clk) begin
        if (init_busy)
            mem[cnt] <= INIT_WORD;
        else if (d_go && d_ok && dbg_we)
            for (int i = 0; i < BW; i++)
                if (dbg_be[i]) mem[d_idx[IW-1:0]][8*i +: 8] <= dbg_wdata[8*i +: 8];
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_INIT;
            cnt <= '0;
            fetch_valid <= 1'b0;
            fetch_data <= '0;
            fetch_err <= 1'b0;
            dbg_ack <= 1'b0;
            dbg_rdata <= '0;
            dbg_err <= 1'b0;
        end else begin
            fetch_valid <= f_go;
            dbg_ack <= d_go;
            if (state == S_INIT) begin
                cnt <= cnt + IW'(1);
                if (cnt == IW'(DEPTH - 1)) state <= S_RUN;
            end
            if (f_go) begin
                fetch_data <= f_ok ? mem[f_idx[IW-1:0]] : '0;
                fetch_err <= !f_ok;
            end
            if (d_go) begin
                dbg_rdata <= d_ok ? mem[d_idx[IW-1:0]] : '0;
                dbg_err <= !d_ok;
            end
        end
    end
endmodule

// File: tb/tb_imem_dp.sv
// tb_imem_dp: randomized self-checking bench for imem_dp against a word-array reference model
module tb_imem_dp;
    localparam int DEPTH = 16;
    localparam logic [31:0] INIT = 32'h00000013;

    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_ready, fetch_valid, fetch_err;
    logic [31:0] fetch_data;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [3:0]  dbg_be = '0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic        dbg_ready, dbg_ack, dbg_err, init_busy;
    logic [31:0] dbg_rdata;

    logic [31:0] model [DEPTH];
    int n_chk = 0, n_pass = 0;

    imem_dp #(.DEPTH(DEPTH), .DATA_WIDTH(32), .ADDR_WIDTH(32), .INIT_WORD(INIT)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_be(dbg_be), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready), .dbg_ack(dbg_ack),
        .dbg_rdata(dbg_rdata), .dbg_err(dbg_err), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic addr_ok(input logic [31:0] a);
        return a < 32'(DEPTH * 4) && a[1:0] == 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return addr_ok(a) ? model[a / 4] : 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        if (!addr_ok(a)) return;
        for (int i = 0; i < 4; i++)
            if (be[i]) model[a / 4][8*i +: 8] = wd[8*i +: 8];
    endtask

    task automatic model_init;
        for (int i = 0; i < DEPTH; i++) model[i] = INIT;
    endtask

    task automatic fetch(input logic [31:0] a, output logic v, output logic [31:0] d, output logic e);
        fetch_req = 1'b1;
        fetch_addr = a;
        step;
        fetch_req = 1'b0;
        v = fetch_valid;
        d = fetch_data;
        e = fetch_err;
    endtask

    task automatic dbg(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd,
                       output logic ack, output logic [31:0] rd, output logic err);
        dbg_req = 1'b1;
        dbg_we = we;
        dbg_be = be;
        dbg_addr = a;
        dbg_wdata = wd;
        step;
        dbg_req = 1'b0;
        dbg_we = 1'b0;
        ack = dbg_ack;
        rd = dbg_rdata;
        err = dbg_err;
    endtask

    task automatic count_init(input string tag);
        int n = 0;
        while (init_busy && n < 64) begin
            step;
            n++;
        end
        n_chk++; if (n !== DEPTH) $display("FAIL %s_init_len got %0d want %0d", tag, n, DEPTH); else n_pass++;
        model_init();
    endtask

    task automatic test_reset;
        logic [31:0] d;
        #1;
        n_chk++; if ({init_busy, fetch_ready, dbg_ready} !== 3'b100) $display("FAIL rst_flags got %b want 100", {init_busy, fetch_ready, dbg_ready}); else n_pass++;
        n_chk++; if ({fetch_valid, fetch_err, dbg_ack, dbg_err, fetch_data, dbg_rdata} !== '0) $display("FAIL rst_outputs got %b/%h/%h want 0", {fetch_valid, fetch_err, dbg_ack, dbg_err}, fetch_data, dbg_rdata); else n_pass++;
        step;
        step;
        sys_rst_n = 1'b1;
        fetch_req = 1'b1;
        fetch_addr = 32'h0;
        count_init("rst");
        n_chk++; if ({fetch_ready, dbg_ready, fetch_valid} !== 3'b110) $display("FAIL rst_ready got %b want 110", {fetch_ready, dbg_ready, fetch_valid}); else n_pass++;
        step;
        fetch_req = 1'b0;
        n_chk++; if ({fetch_valid, fetch_err, fetch_data} !== {2'b10, INIT}) $display("FAIL rst_first_fetch got %b/%b/%h want 1/0/%h", fetch_valid, fetch_err, fetch_data, INIT); else n_pass++;
        step;
        d = fetch_data;
        n_chk++; if ({fetch_valid, d} !== {1'b0, INIT}) $display("FAIL rst_hold got %b/%h want 0/%h", fetch_valid, d, INIT); else n_pass++;
    endtask

    task automatic test_byte_enable;
        logic ack, err, v, e;
        logic [31:0] rd, d;
        dbg(1'b1, 4'b1111, 32'h8, 32'hDEADBEEF, ack, rd, err);
        model_write(32'h8, 4'b1111, 32'hDEADBEEF);
        n_chk++; if ({ack, err, rd} !== {2'b10, INIT}) $display("FAIL be_wr1 got %b/%b/%h want 1/0/%h", ack, err, rd, INIT); else n_pass++;
        dbg(1'b1, 4'b0010, 32'h8, 32'h00005500, ack, rd, err);
        model_write(32'h8, 4'b0010, 32'h00005500);
        n_chk++; if ({ack, err, rd} !== {2'b10, 32'hDEADBEEF}) $display("FAIL be_wr2 got %b/%b/%h want 1/0/deadbeef", ack, err, rd); else n_pass++;
        dbg(1'b1, 4'b0000, 32'h8, 32'hFFFFFFFF, ack, rd, err);
        n_chk++; if ({ack, err} !== 2'b10) $display("FAIL be_noop_ack got %b want 10", {ack, err}); else n_pass++;
        fetch(32'h8, v, d, e);
        n_chk++; if ({v, e, d} !== {2'b10, 32'hDEAD55EF}) $display("FAIL be_fetch got %b/%b/%h want 1/0/dead55ef", v, e, d); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic ack, err;
        logic [31:0] rd, w;
        int good = 0;
        for (int i = 0; i < 11; i++) begin
            w = $urandom;
            dbg(1'b1, 4'hF, 32'(4 * i), w, ack, rd, err);
            model_write(32'(4 * i), 4'hF, w);
        end
        fetch_req = 1'b1;
        fetch_addr = 32'h0;
        for (int i = 0; i < 11; i++) begin
            step;
            if (i < 10) fetch_addr = 32'(4 * (i + 1)); else fetch_req = 1'b0;
            if (fetch_valid === 1'b1 && fetch_err === 1'b0 && fetch_data === model[i]) good++;
            else $display("FAIL b2b_word%0d got %b/%b/%h want 1/0/%h", i, fetch_valid, fetch_err, fetch_data, model[i]);
        end
        n_chk++; if (good !== 11) $display("FAIL b2b_count got %0d want 11", good); else n_pass++;
        step;
        n_chk++; if (fetch_valid !== 1'b0) $display("FAIL b2b_end got %b want 0", fetch_valid); else n_pass++;
    endtask

    task automatic test_arbitration;
        fetch_req = 1'b1;
        fetch_addr = 32'h14;
        dbg_req = 1'b1;
        dbg_we = 1'b0;
        dbg_addr = 32'h4;
        #1;
        n_chk++; if ({fetch_ready, dbg_ready} !== 2'b01) $display("FAIL arb_ready got %b want 01", {fetch_ready, dbg_ready}); else n_pass++;
        step;
        dbg_req = 1'b0;
        n_chk++; if ({dbg_ack, fetch_valid, dbg_rdata} !== {2'b10, model[1]}) $display("FAIL arb_dbg got %b/%b/%h want 1/0/%h", dbg_ack, fetch_valid, dbg_rdata, model[1]); else n_pass++;
        #1;
        n_chk++; if (fetch_ready !== 1'b1) $display("FAIL arb_release got %b want 1", fetch_ready); else n_pass++;
        step;
        fetch_req = 1'b0;
        n_chk++; if ({fetch_valid, dbg_ack, fetch_data} !== {2'b10, model[5]}) $display("FAIL arb_fetch got %b/%b/%h want 1/0/%h", fetch_valid, dbg_ack, fetch_data, model[5]); else n_pass++;
    endtask

    task automatic test_errors;
        logic ack, err, v, e;
        logic [31:0] rd, d;
        int bad = 0;
        fetch(32'h2, v, d, e);
        n_chk++; if ({v, e, d} !== {2'b11, 32'h0}) $display("FAIL err_misaligned got %b/%b/%h want 1/1/0", v, e, d); else n_pass++;
        fetch(32'(DEPTH * 4), v, d, e);
        n_chk++; if ({v, e, d} !== {2'b11, 32'h0}) $display("FAIL err_range got %b/%b/%h want 1/1/0", v, e, d); else n_pass++;
        fetch(32'(DEPTH * 4 - 4), v, d, e);
        n_chk++; if ({v, e, d} !== {2'b10, model[DEPTH-1]}) $display("FAIL err_last_word got %b/%b/%h want 1/0/%h", v, e, d, model[DEPTH-1]); else n_pass++;
        dbg(1'b1, 4'hF, 32'(DEPTH * 4), 32'hA5A5A5A5, ack, rd, err);
        n_chk++; if ({ack, err, rd} !== {2'b11, 32'h0}) $display("FAIL err_dbg_range got %b/%b/%h want 1/1/0", ack, err, rd); else n_pass++;
        dbg(1'b1, 4'hF, 32'h6, 32'h5A5A5A5A, ack, rd, err);
        n_chk++; if ({ack, err, rd} !== {2'b11, 32'h0}) $display("FAIL err_dbg_misaligned got %b/%b/%h want 1/1/0", ack, err, rd); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            fetch(32'(4 * i), v, d, e);
            if (d !== model[i] || e !== 1'b0) begin
                bad++;
                $display("FAIL err_readback%0d got %h want %h", i, d, model[i]);
            end
        end
        n_chk++; if (bad !== 0) $display("FAIL err_readback_total got %0d bad words want 0", bad); else n_pass++;
    endtask

    task automatic test_random;
        logic ack, err, v, e, we;
        logic [31:0] a, rd, d, w, exp;
        logic [3:0] be;
        int bad = 0;
        for (int n = 0; n < 200; n++) begin
            a = $urandom_range(0, DEPTH * 4 + 7);
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 1) begin
                we = 1'($urandom);
                be = 4'($urandom);
                w = $urandom;
                exp = model_read(a);
                dbg(we, be, a, w, ack, rd, err);
                if (we) model_write(a, be, w);
                if ({ack, err, rd} !== {1'b1, !addr_ok(a), exp}) begin
                    bad++;
                    $display("FAIL rnd_dbg a=%h got %b/%b/%h want 1/%b/%h", a, ack, err, rd, !addr_ok(a), exp);
                end
            end else begin
                fetch(a, v, d, e);
                if ({v, e, d} !== {1'b1, !addr_ok(a), model_read(a)}) begin
                    bad++;
                    $display("FAIL rnd_fetch a=%h got %b/%b/%h want 1/%b/%h", a, v, e, d, !addr_ok(a), model_read(a));
                end
            end
        end
        n_chk++; if (bad !== 0) $display("FAIL rnd_total got %0d errors want 0", bad); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic ack, err, v, e;
        logic [31:0] rd, d;
        sys_rst_n = 1'b0;
        #1;
        sys_rst_n = 1'b1;
        repeat (5) step;
        sys_rst_n = 1'b0;
        #1;
        n_chk++; if ({init_busy, dbg_ready, fetch_ready} !== 3'b100) $display("FAIL mid_init_flags got %b want 100", {init_busy, dbg_ready, fetch_ready}); else n_pass++;
        step;
        sys_rst_n = 1'b1;
        count_init("mid_init");
        dbg(1'b1, 4'hF, 32'h4, 32'h12345678, ack, rd, err);
        fetch_req = 1'b1;
        fetch_addr = 32'h4;
        step;
        fetch_req = 1'b0;
        n_chk++; if ({fetch_valid, fetch_data} !== {1'b1, 32'h12345678}) $display("FAIL mid_pending got %b/%h want 1/12345678", fetch_valid, fetch_data); else n_pass++;
        sys_rst_n = 1'b0;
        #1;
        n_chk++; if ({fetch_valid, fetch_err, dbg_ack, dbg_err, fetch_data, dbg_rdata} !== '0) $display("FAIL mid_async_clear got %b/%h/%h want 0", {fetch_valid, fetch_err, dbg_ack, dbg_err}, fetch_data, dbg_rdata); else n_pass++;
        n_chk++; if (init_busy !== 1'b1) $display("FAIL mid_busy got %b want 1", init_busy); else n_pass++;
        step;
        sys_rst_n = 1'b1;
        count_init("mid_fetch");
        fetch(32'h4, v, d, e);
        n_chk++; if ({v, e, d} !== {2'b10, INIT}) $display("FAIL mid_reinit got %b/%b/%h want 1/0/%h", v, e, d, INIT); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_back_to_back();
        test_arbitration();
        test_errors();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/imem_dp.md
# imem_dp

Parameterised instruction memory for the single-cycle/multi-cycle RISC-V cores, replacing the fixed 64-word hard-coded program store. It provides a registered fetch port with a valid/ready handshake and a debug/loader port with byte-enables that lets the debug UART path download programs at run time. After every reset, a built-in init sequencer fills the array with a configurable word before either port is accepted. Misaligned or out-of-range accesses are flagged rather than aliased.

## Interface
- DEPTH, 256, number of DATA_WIDTH-bit words; any value ≥ 2; index width IW = clog2(DEPTH)
- DATA_WIDTH, 32, word width; multiple of 8
- ADDR_WIDTH, 32, byte-address width of both ports
- INIT_WORD, 32'h00000013, value written to every word by the init sequencer (RISC-V NOP)
- clk  in  1  single clock, all logic on posedge
- sys_rst_n  in  1  reset, asynchronous assert, active-low
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_WIDTH  fetch byte address
- fetch_ready  out  1  fetch port can accept this cycle
- fetch_valid  out  1  fetch_data/fetch_err valid, one-cycle pulse
- fetch_data  out  DATA_WIDTH  fetched word
- fetch_err  out  1  misaligned or out-of-range fetch
- dbg_req  in  1  debug access request
- dbg_we  in  1  1 = write, 0 = read
- dbg_be  in  DATA_WIDTH/8  byte enables for writes
- dbg_addr  in  ADDR_WIDTH  debug byte address
- dbg_wdata  in  DATA_WIDTH  write data
- dbg_ready  out  1  debug port can accept this cycle
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_WIDTH  read data (read-before-write on writes)
- dbg_err  out  1  misaligned or out-of-range debug access
- init_busy  out  1  init sequencer active

## Operation
- Word index = addr[ADDR_WIDTH-1:2]. Access is in range iff index < DEPTH. Access is aligned iff addr[1:0] == 0.
- FSM states:
  - INIT (reset state): counter cnt from 0 writes INIT_WORD to RAM[cnt] each cycle. After cnt == DEPTH-1 is written, go to RUN.
  - RUN: serves both ports. No other transitions except reset.
- init_busy = (state == INIT); dbg_ready = !init_busy; fetch_ready = !init_busy && !dbg_req.
- Arbitration: the array is single-ported and the debug port has priority. fetch_ready drops combinationally while dbg_req is high. A fetch_req without fetch_ready is ignored; it is not queued, and the master holds it.
- Fetch accepted (fetch_req && fetch_ready):
  - In range and aligned: fetch_data = RAM[index], fetch_err = 0.
  - Otherwise: fetch_data = 0, fetch_err = 1.
- Debug accepted (dbg_req && dbg_ready):
  - In range and aligned: dbg_rdata = RAM[index] (value before the write). If dbg_we, each byte lane i with dbg_be[i] = 1 is replaced by dbg_wdata lane i; other lanes are unchanged. dbg_we with dbg_be = 0 is a legal no-op write, still acked.
  - Otherwise: no array change, dbg_rdata = 0, dbg_err = 1.
- The array itself is not reset. Only state, cnt and outputs are reset.

## Timing
- Reset values (while sys_rst_n = 0): state = INIT, cnt = 0, init_busy = 1, fetch_ready = 0, dbg_ready = 0, fetch_valid = 0, fetch_data = 0, fetch_err = 0, dbg_ack = 0, dbg_rdata = 0, dbg_err = 0.
- Init: init_busy stays high for exactly DEPTH rising edges after reset release, then goes low.
- Fetch latency is 1: a request accepted at edge N gives fetch_valid = 1 with data/err after edge N, for one cycle. Back-to-back fetches every cycle give full throughput. fetch_data/fetch_err hold their last values when fetch_valid = 0.
- Debug latency is 1: dbg_ack/dbg_rdata/dbg_err follow the accepting edge by one cycle. A write is visible to any access accepted at the next edge or later.
- Simultaneous fetch_req and dbg_req: debug is served and the fetch is stalled that cycle; fetch_valid = 0 the following cycle.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous), any pending valid/ack is lost, and INIT restarts from cnt = 0 after release.

## Test plan
- Reset release with DEPTH = 16 -> init_busy high for 16 cycles; fetch_req held at addr 0x0 accepted on cycle 16; fetch_valid the next cycle with fetch_data = 0x00000013, fetch_err = 0.
- Debug write addr 0x8, data 0xDEADBEEF, be = 4'b1111, then be = 4'b0010 with data 0x00005500 -> a fetch of 0x8 returns 0xDEAD55EF; the second write's dbg_rdata = 0xDEADBEEF.
- Load an 11-word program via the debug port, then fetch 0x0..0x28 back-to-back -> 11 consecutive fetch_valid pulses with matching words and no bubbles.
- fetch_req and dbg_req asserted together -> fetch_ready = 0 that cycle; debug ack next cycle; fetch accepted one cycle later.
- Fetch 0x2 and fetch DEPTH*4 -> fetch_err = 1, fetch_data = 0; debug write to DEPTH*4 -> dbg_err = 1 and no word changed (full readback check).
- Assert sys_rst_n low during INIT at cnt = 5 and during a pending fetch -> outputs zero immediately, init_busy = 1, and the full DEPTH-cycle init is repeated after release.
